// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage hazard/redirect controller for a 5-stage pipeline.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   haz_ld     in   load-use hazard in ID; hold fetch one cycle
//   call_req   in   call resolved in EX
//   br_taken   in   taken branch resolved in EX
//   ret_req    in   return decoded in EX; target not yet available
//   ret_valid  in   return target available from MEM
//   halt_req   in   halt instruction reached EX
//   resume     in   leave HALT
//   stall      out  freeze PC in fetch stage
//   Call       out  PC-redirect select: call target
//   Branch     out  PC-redirect select: branch target
//   Ret        out  PC-redirect select: return target
//   flush      out  squash IF/ID and ID/EX this cycle
//   halted     out  controller is in HALT
//   stall_cnt  out  saturating count of stall cycles since reset
//   state_dbg  out  current FSM state (BOOT=0, RUN=1, RETW=2, HALT=3)
//
// Handshake: there is no valid/ready pairing here. Every request input is a
// single-cycle level sampled combinationally; its effect on the outputs is
// visible in the same cycle and the state change lands on the next rising edge.

module fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        haz_ld,
  input  logic        call_req,
  input  logic        br_taken,
  input  logic        ret_req,
  input  logic        ret_valid,
  input  logic        halt_req,
  input  logic        resume,
  output logic        stall,
  output logic        Call,
  output logic        Branch,
  output logic        Ret,
  output logic        flush,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    RETW = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Mealy outputs.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    Call    = 1'b0;
    Branch  = 1'b0;
    Ret     = 1'b0;
    halted  = 1'b0;
    case (state_q)
      BOOT: begin
        // One cycle for the instruction memory read enable to settle.
        stall   = 1'b1;
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        // Fixed priority: call > branch > return > halt > load-use hazard.
        if (call_req) begin
          Call  = 1'b1;
          flush = 1'b1;
        end else if (br_taken) begin
          Branch = 1'b1;
          flush  = 1'b1;
        end else if (ret_req) begin
          stall   = 1'b1;
          flush   = 1'b1;
          state_d = RETW;
        end else if (halt_req) begin
          stall   = 1'b1;
          flush   = 1'b1;
          state_d = HALT;
        end else if (haz_ld) begin
          stall = 1'b1;
        end
      end
      RETW: begin
        // Everything except ret_valid is ignored while the target is in flight.
        flush = 1'b1;
        if (ret_valid) begin
          Ret     = 1'b1;
          state_d = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      HALT: begin
        // stall stays high in the resume cycle; fetch restarts from RUN.
        stall  = 1'b1;
        halted = 1'b1;
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state_dbg = state_q;

endmodule
